// File: rtl/lfsr_pkg.sv
// Shared definitions for the 8-bit Galois LFSR pattern generator and checker:
// default width/polynomial, checker state encoding and the reference step function.
package lfsr_pkg;

    localparam int unsigned        NB_DATA = 8;
    localparam logic [NB_DATA-1:0] POLY    = 8'hB8;  // x^8+x^6+x^5+x^4+1

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_SYNC     = 2'd1,
        ST_LOCKED   = 2'd2
    } state_e;

    function automatic logic [NB_DATA-1:0] lfsr_step(input logic [NB_DATA-1:0] s,
                                                     input logic [NB_DATA-1:0] poly);
        return (s >> 1) ^ (s[0] ? poly : '0);
    endfunction

endpackage

// File: rtl/lfsr_galois_step.sv
// Combinational one-step advance of a right-shifting Galois LFSR.
module lfsr_galois_step #(
    parameter int unsigned        NB_DATA = lfsr_pkg::NB_DATA,
    parameter logic [NB_DATA-1:0] POLY    = lfsr_pkg::POLY
) (
    input  logic [NB_DATA-1:0] i_state,
    output logic [NB_DATA-1:0] o_next
);

    assign o_next = {1'b0, i_state[NB_DATA-1:1]} ^ (i_state[0] ? POLY : '0);

endmodule

// File: rtl/lfsr_galois_checker.sv
// Receive-side checker: self-seeds, locks on a predicted LFSR stream and counts word errors.
// Define LFSR_CHK_BER_EN to add the saturating bit-error counter output o_bit_err_cnt.
module lfsr_galois_checker #(
    parameter int unsigned        NB_DATA    = lfsr_pkg::NB_DATA,
    parameter logic [NB_DATA-1:0] POLY       = lfsr_pkg::POLY,
    parameter int unsigned        LOCK_CNT   = 5,
    parameter int unsigned        UNLOCK_CNT = 3,
    parameter int unsigned        NB_ERR     = 16
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_soft_reset,
    input  logic               i_valid,
    input  logic [NB_DATA-1:0] i_data,
    output logic               o_lock,
    output logic               o_err,
    output logic [NB_ERR-1:0]  o_err_cnt,
`ifdef LFSR_CHK_BER_EN
    output logic [NB_ERR-1:0]  o_bit_err_cnt,
`endif
    output logic [1:0]         o_state
);

    import lfsr_pkg::*;

    localparam int unsigned NB_MCNT = $clog2(LOCK_CNT + 1);
    localparam int unsigned NB_UCNT = $clog2(UNLOCK_CNT + 1);
    localparam logic [NB_MCNT-1:0] LOCK_LAST   = NB_MCNT'(LOCK_CNT - 1);
    localparam logic [NB_UCNT-1:0] UNLOCK_LAST = NB_UCNT'(UNLOCK_CNT - 1);

    state_e              r_state,     w_state_nxt;
    logic [NB_DATA-1:0]  r_ref,       w_ref_nxt;
    logic [NB_MCNT-1:0]  r_match_cnt, w_match_nxt;
    logic [NB_UCNT-1:0]  r_miss_cnt,  w_miss_nxt;
    logic                r_err,       w_err_nxt;
    logic [NB_ERR-1:0]   r_err_cnt,   w_err_cnt_nxt;
    logic [NB_DATA-1:0]  w_step_data;
    logic [NB_DATA-1:0]  w_step_ref;
    logic                w_hit;

    lfsr_galois_step #(.NB_DATA(NB_DATA), .POLY(POLY)) u_step_data (
        .i_state (i_data),
        .o_next  (w_step_data)
    );

    lfsr_galois_step #(.NB_DATA(NB_DATA), .POLY(POLY)) u_step_ref (
        .i_state (r_ref),
        .o_next  (w_step_ref)
    );

    assign w_hit = (i_data == r_ref);

`ifdef LFSR_CHK_BER_EN
    localparam int unsigned NB_POP = $clog2(NB_DATA + 1);
    localparam int unsigned NB_SUM = NB_ERR + 1;

    logic [NB_ERR-1:0]  r_bit_err_cnt, w_bit_err_nxt;
    logic [NB_DATA-1:0] w_diff;
    logic [NB_POP-1:0]  w_pop;
    logic [NB_ERR:0]    w_ber_sum;

    assign w_diff = i_data ^ r_ref;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < int'(NB_DATA); i++) begin
            w_pop = w_pop + NB_POP'(w_diff[i]);
        end
    end

    assign w_ber_sum = {1'b0, r_bit_err_cnt} + NB_SUM'(w_pop);
`endif

    // State register
    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= ST_UNLOCKED;
            r_ref       <= '0;
            r_match_cnt <= '0;
            r_miss_cnt  <= '0;
            r_err       <= 1'b0;
            r_err_cnt   <= '0;
`ifdef LFSR_CHK_BER_EN
            r_bit_err_cnt <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_ref       <= w_ref_nxt;
            r_match_cnt <= w_match_nxt;
            r_miss_cnt  <= w_miss_nxt;
            r_err       <= w_err_nxt;
            r_err_cnt   <= w_err_cnt_nxt;
`ifdef LFSR_CHK_BER_EN
            r_bit_err_cnt <= w_bit_err_nxt;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt   = r_state;
        w_ref_nxt     = r_ref;
        w_match_nxt   = r_match_cnt;
        w_miss_nxt    = r_miss_cnt;
        w_err_nxt     = 1'b0;
        w_err_cnt_nxt = r_err_cnt;
`ifdef LFSR_CHK_BER_EN
        w_bit_err_nxt = r_bit_err_cnt;
`endif

        if (i_soft_reset) begin
            w_state_nxt   = ST_UNLOCKED;
            w_ref_nxt     = '0;
            w_match_nxt   = '0;
            w_miss_nxt    = '0;
            w_err_cnt_nxt = '0;
`ifdef LFSR_CHK_BER_EN
            w_bit_err_nxt = '0;
`endif
        end else if (r_state != ST_UNLOCKED && r_state != ST_SYNC && r_state != ST_LOCKED) begin
            // Unused encoding recovers without waiting for a valid word
            w_state_nxt = ST_UNLOCKED;
            w_match_nxt = '0;
            w_miss_nxt  = '0;
        end else if (i_valid) begin
            case (r_state)
                ST_UNLOCKED: begin
                    if (i_data != '0) begin
                        w_ref_nxt   = w_step_data;
                        w_match_nxt = '0;
                        w_state_nxt = ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    if (w_hit) begin
                        w_ref_nxt = w_step_data;
                        if (r_match_cnt == LOCK_LAST) begin
                            w_match_nxt = '0;
                            w_miss_nxt  = '0;
                            w_state_nxt = ST_LOCKED;
                        end else begin
                            w_match_nxt = r_match_cnt + 1'b1;
                        end
                    end else if (i_data != '0) begin
                        w_ref_nxt   = w_step_data;
                        w_match_nxt = '0;
                    end else begin
                        w_match_nxt = '0;
                        w_state_nxt = ST_UNLOCKED;
                    end
                end
                ST_LOCKED: begin
                    // Free-run the prediction so corrupted words never reseed it
                    w_ref_nxt = w_step_ref;
`ifdef LFSR_CHK_BER_EN
                    w_bit_err_nxt = w_ber_sum[NB_ERR] ? '1 : w_ber_sum[NB_ERR-1:0];
`endif
                    if (w_hit) begin
                        w_miss_nxt = '0;
                    end else begin
                        w_err_nxt = 1'b1;
                        if (r_err_cnt != '1) begin
                            w_err_cnt_nxt = r_err_cnt + 1'b1;
                        end
                        if (r_miss_cnt == UNLOCK_LAST) begin
                            w_miss_nxt  = '0;
                            w_state_nxt = ST_UNLOCKED;
                        end else begin
                            w_miss_nxt = r_miss_cnt + 1'b1;
                        end
                    end
                end
                default: w_state_nxt = ST_UNLOCKED;
            endcase
        end
    end

    // Outputs, all driven from registers
    always_comb begin
        o_lock    = (r_state == ST_LOCKED);
        o_err     = r_err;
        o_err_cnt = r_err_cnt;
        o_state   = r_state;
`ifdef LFSR_CHK_BER_EN
        o_bit_err_cnt = r_bit_err_cnt;
`endif
    end

endmodule

// File: tb/tb_lfsr_galois_checker.sv
// Directed bench for lfsr_galois_checker; expected values are hand-computed LFSR words.
module tb_lfsr_galois_checker;

    logic        clk;
    logic        i_rst;
    logic        i_soft_reset;
    logic        i_valid;
    logic [7:0]  i_data;
    logic        o_lock;
    logic        o_err;
    logic [15:0] o_err_cnt;
    logic [1:0]  o_state;
`ifdef LFSR_CHK_BER_EN
    logic [15:0] o_bit_err_cnt;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    lfsr_galois_checker u_dut (
        .clk          (clk),
        .i_rst        (i_rst),
        .i_soft_reset (i_soft_reset),
        .i_valid      (i_valid),
        .i_data       (i_data),
        .o_lock       (o_lock),
        .o_err        (o_err),
        .o_err_cnt    (o_err_cnt),
`ifdef LFSR_CHK_BER_EN
        .o_bit_err_cnt(o_bit_err_cnt),
`endif
        .o_state      (o_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one word on the falling edge; it is sampled on the next rising edge
    task automatic put(input logic [7:0] d, input logic v);
        @(negedge clk);
        i_valid = v;
        i_data  = d;
    endtask

    // Correct stream from seed 0xAA; optional idle gaps between valid words
    task automatic lock_seq(input bit gaps);
        logic [7:0] seq [6];
        seq = '{8'hAA, 8'h55, 8'h92, 8'h49, 8'h9C, 8'h4E};
        for (int i = 0; i < 6; i++) begin
            if (i == 5) begin
                put(8'h00, 1'b0);
                check_val("no_early_lock", {30'd0, o_state}, 32'd1);
                check_val("no_early_lock_flag", {31'd0, o_lock}, 32'd0);
            end
            put(seq[i], 1'b1);
            if (gaps) begin
                repeat (1 + (i % 3)) put(8'($urandom), 1'b0);
            end
        end
        put(8'h00, 1'b0);
    endtask

    initial begin
        i_rst        = 1'b0;
        i_soft_reset = 1'b0;
        i_valid      = 1'b0;
        i_data       = 8'h00;
        repeat (2) @(negedge clk);
        check_val("rst_lock", {31'd0, o_lock}, 32'd0);
        check_val("rst_state", {30'd0, o_state}, 32'd0);
        check_val("rst_err", {31'd0, o_err}, 32'd0);
        check_val("rst_err_cnt", {16'd0, o_err_cnt}, 32'd0);
        i_rst = 1'b1;

        // Lockup value ignored while unlocked
        put(8'h00, 1'b1);
        put(8'h00, 1'b0);
        check_val("zero_ignored", {30'd0, o_state}, 32'd0);

        lock_seq(1'b0);
        check_val("lock_flag", {31'd0, o_lock}, 32'd1);
        check_val("lock_state", {30'd0, o_state}, 32'd2);
        check_val("lock_err_cnt", {16'd0, o_err_cnt}, 32'd0);

        // 0x00 replaces 0x27, then stream continues with 0xAB
        put(8'h00, 1'b1);
        put(8'hAB, 1'b1);
        check_val("single_err_pulse", {31'd0, o_err}, 32'd1);
        check_val("single_err_cnt", {16'd0, o_err_cnt}, 32'd1);
        put(8'h00, 1'b0);
        check_val("single_err_pulse_end", {31'd0, o_err}, 32'd0);
        check_val("single_err_lock", {31'd0, o_lock}, 32'd1);
        check_val("single_err_cnt_hold", {16'd0, o_err_cnt}, 32'd1);

        // Asynchronous reset mid-cycle
        @(negedge clk);
        #2 i_rst = 1'b0;
        #1;
        check_val("async_rst_lock", {31'd0, o_lock}, 32'd0);
        check_val("async_rst_cnt", {16'd0, o_err_cnt}, 32'd0);
        check_val("async_rst_state", {30'd0, o_state}, 32'd0);
        @(posedge clk);
        i_rst = 1'b1;
        @(negedge clk);
        check_val("rst_release_state", {30'd0, o_state}, 32'd0);

        // Relock with idle gaps, then three wrong words (expected 0x27, 0xAB, 0xED)
        lock_seq(1'b1);
        check_val("gap_lock", {31'd0, o_lock}, 32'd1);
        put(8'h11, 1'b1);
        put(8'h11, 1'b1);
        put(8'h00, 1'b0);
        check_val("unlock_2nd_lock", {31'd0, o_lock}, 32'd1);
        check_val("unlock_2nd_cnt", {16'd0, o_err_cnt}, 32'd2);
        put(8'h11, 1'b1);
        put(8'h00, 1'b0);
        check_val("unlock_err_pulse", {31'd0, o_err}, 32'd1);
        check_val("unlock_err_cnt", {16'd0, o_err_cnt}, 32'd3);
        check_val("unlock_lock", {31'd0, o_lock}, 32'd0);
        check_val("unlock_state", {30'd0, o_state}, 32'd0);

        // Relock, single-bit error 0x27 -> 0x26, then soft reset over a valid word
        lock_seq(1'b0);
        check_val("relock", {31'd0, o_lock}, 32'd1);
        check_val("relock_cnt_kept", {16'd0, o_err_cnt}, 32'd3);
        put(8'h26, 1'b1);
        put(8'h00, 1'b0);
        check_val("bit_err_cnt_word", {16'd0, o_err_cnt}, 32'd4);
`ifdef LFSR_CHK_BER_EN
        check_val("bit_err_cnt_ber", {16'd0, o_bit_err_cnt}, 32'd1);
`endif
        @(negedge clk);
        i_soft_reset = 1'b1;
        i_valid      = 1'b1;
        i_data       = 8'hAB;
        @(negedge clk);
        i_soft_reset = 1'b0;
        i_valid      = 1'b0;
        check_val("soft_rst_lock", {31'd0, o_lock}, 32'd0);
        check_val("soft_rst_cnt", {16'd0, o_err_cnt}, 32'd0);
        check_val("soft_rst_state", {30'd0, o_state}, 32'd0);
`ifdef LFSR_CHK_BER_EN
        check_val("soft_rst_ber", {16'd0, o_bit_err_cnt}, 32'd0);
`endif
        lock_seq(1'b1);
        check_val("soft_relock", {31'd0, o_lock}, 32'd1);
        check_val("soft_relock_state", {30'd0, o_state}, 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/lfsr_galois_checker.md
Name: lfsr_galois_checker

Overview:
- Receive-side checker for the 8-bit Galois LFSR pattern generator.
- Takes the generated word stream, self-seeds from the first non-zero word, then predicts every following word.
- Declares lock after LOCK_CNT consecutive correct predictions and drops lock after UNLOCK_CNT consecutive mispredictions.
- Counts word errors while locked. Sits at the far end of the generator in the top-level loopback.

Parameters:
- NB_DATA, 8: LFSR/word width.
- POLY, 8'hB8: Galois feedback mask (x^8+x^6+x^5+x^4+1).
- LOCK_CNT, 5: consecutive matches in SYNC needed to lock.
- UNLOCK_CNT, 3: consecutive mismatches in LOCKED needed to unlock.
- NB_ERR, 16: error counter width.

Ports:
- clk  in  1  system clock, rising edge.
- i_rst  in  1  asynchronous active-low reset.
- i_soft_reset  in  1  synchronous clear of state, counters and reference; active-high.
- i_valid  in  1  i_data qualifier.
- i_data  in  NB_DATA  received LFSR word.
- o_lock  out  1  checker locked.
- o_err  out  1  one-cycle pulse on each mismatched word while LOCKED.
- o_err_cnt  out  NB_ERR  saturating error count.
- o_state  out  2  current FSM state, for debug.

Behaviour:
- Step function: step(s) = (s>>1) ^ (s[0] ? POLY : 0).
- Reset: i_rst low sets all outputs 0, state UNLOCKED, ref 0, match_cnt 0, miss_cnt 0, asynchronously. i_soft_reset high at a clock edge does the same synchronously and has priority over i_valid.
- All outputs are registered. They reflect a valid word one cycle after the edge that samples it.
- With i_valid=0, state, counters and ref hold; no step is taken.
- State UNLOCKED (2'd0):
  - Valid word with data!=0: ref<=step(data), match_cnt<=0, go to SYNC.
  - data==0 is the lockup value: ignore it and stay.
- State SYNC (2'd1), on a valid word:
  - data==ref: ref<=step(data), match_cnt++. If match_cnt+1==LOCK_CNT, go to LOCKED with o_lock<=1 and clear match_cnt.
  - data!=ref and data!=0: reseed with ref<=step(data), match_cnt<=0, stay in SYNC.
  - data!=ref and data==0: go to UNLOCKED.
- State LOCKED (2'd2), on a valid word:
  - ref<=step(ref) always. ref is never reloaded from data in this state, so bit errors do not corrupt the prediction.
  - Match: miss_cnt<=0.
  - Mismatch: o_err<=1 for one cycle, o_err_cnt++ (saturating at all-ones, no wrap), miss_cnt++.
  - If miss_cnt+1==UNLOCK_CNT: go to UNLOCKED, o_lock<=0, miss_cnt<=0.
- o_err_cnt is cleared only by i_rst or i_soft_reset. It is not cleared by loss of lock.
- State encoding 2'd3 is unused and recovers to UNLOCKED on the next clock.
- Latency: the earliest o_lock is 1 load word + LOCK_CNT matching words, asserted the cycle after the last of them.
- Reset mid-stream: discard everything; the next valid non-zero word is treated as a fresh seed.

Optional Feature:
- Macro LFSR_CHK_BER_EN.
- When defined: adds output o_bit_err_cnt [NB_ERR-1:0]. While LOCKED, each valid word adds popcount(data^ref) with saturation. Same clear rules as o_err_cnt.
- When undefined: the port and its logic are absent, and word-level counting is unchanged.

Decomposition:
- Shared package/header lfsr_pkg: NB_DATA, POLY default, state encodings (ST_UNLOCKED, ST_SYNC, ST_LOCKED), and the step function. The generator reuses the same header.
- One sub-module lfsr_galois_step: combinational next-state computation, instantiated for step(data) and step(ref).

Test Plan:
- Reset: assert i_rst=0 mid-cycle -> all outputs 0 immediately; release at posedge -> o_state=0.
- Lock: valid words 0xAA,0x55,0x92,0x49,0x9C,0x4E -> o_lock=1 and o_state=2 one cycle after 0x4E; o_err_cnt=0.
- Single error: after lock, send 0x00 in place of 0x27, then 0xAB -> one o_err pulse, o_err_cnt=1, o_lock stays 1.
- Unlock: after lock, send 3 consecutive wrong words -> o_err_cnt=3, o_lock=0 after the third, o_state=0.
- Zero seed and gaps: 0x00 while UNLOCKED is ignored. Random i_valid gaps during a correct stream do not delay lock beyond 6 valid words.
- Soft reset while locked: i_soft_reset=1 for one edge -> o_lock=0, o_err_cnt=0, and relock needs 6 fresh valid words. With LFSR_CHK_BER_EN defined, 0x27 corrupted to 0x26 gives o_bit_err_cnt=1.
